// File: rtl/wb_block_ram.sv
// wb_block_ram: single-port, byte-addressed synchronous block RAM with a
// pipelined Wishbone-style slave interface (RV32 data memory).
//
// Ports:
//   i_clk       clock, all logic on the rising edge
//   i_reset     synchronous active-high reset (memory contents are kept)
//   i_wb_stb    request strobe, one access per cycle
//   i_addr      byte address, bits above AW-1 ignored (wraps)
//   i_data      right-aligned store data
//   i_wb_we     1 = store, 0 = load
//   i_wb_sel    funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_wb_data   extended load result, valid while o_wb_ack is high (else 0)
//   o_wb_stall  high while reset is asserted
//   o_wb_ack    one-cycle pulse, one cycle after each accepted request
//
// Every word starts at zero; INIT_FILE is ignored.
module wb_block_ram #(
   parameter int XLEN      = 32,
   parameter int AW        = 12,
   parameter     INIT_FILE = ""
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_wb_stb,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_data,
   input  logic            i_wb_we,
   input  logic [2:0]      i_wb_sel,
   output logic [XLEN-1:0] o_wb_data,
   output logic            o_wb_stall,
   output logic            o_wb_ack
);

   localparam int DEPTH  = 2 ** (AW - 2);
   localparam int STAGES = 1;

   // Per-request info carried alongside the read register to the ack cycle.
   typedef struct packed {
      logic       ld;
      logic [2:0] sel;
      logic [1:0] lane;
   } rsp_t;

   logic              accept;
   logic [AW-3:0]     widx;
   logic [3:0]        be;
   logic [3:0][7:0]   wdat;
   logic [3:0][7:0]   rd_q;
   logic              vld_q;
   logic [STAGES:0]   vld_pipe;
   rsp_t              rsp_q;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [XLEN-1:0]   ext;
   logic              unused_addr;

   assign accept      = i_wb_stb & ~i_reset;
   assign widx        = i_addr[AW-1:2];
   assign unused_addr = &{1'b0, i_addr[XLEN-1:AW]};

   // Replicate store data across lanes so the byte enables alone pick the
   // destination; this keeps the write port a plain byte-enable RAM port.
   always_comb begin
      be   = 4'b0000;
      wdat = i_data;
      case (i_wb_sel)
         3'b000: begin
            be   = 4'b0001 << i_addr[1:0];
            wdat = {4{i_data[7:0]}};
         end
         3'b001: begin
            be   = i_addr[1] ? 4'b1100 : 4'b0011;
            wdat = {2{i_data[15:0]}};
         end
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   logic [3:0][7:0] mem [DEPTH] = '{default: '0};
   localparam int unused_init = $bits(INIT_FILE);

   // Array write/read kept free of reset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (accept && i_wb_we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[widx][b] <= wdat[b];
      end
      if (accept && !i_wb_we) rd_q <= mem[widx];
   end

   assign vld_pipe = {vld_q, accept};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         vld_q <= 1'b0;
         rsp_q <= '0;
      end else begin
         vld_q <= vld_pipe[0];
         if (accept) rsp_q <= '{ld: ~i_wb_we, sel: i_wb_sel, lane: i_addr[1:0]};
      end
   end

   // Lane select and extension sit after the read register.
   always_comb begin
      byte_sel = rd_q[rsp_q.lane];
      half_sel = rsp_q.lane[1] ? rd_q[3:2] : rd_q[1:0];
      ext      = '0;
      if (rsp_q.ld) begin
         case (rsp_q.sel)
            3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext = {24'd0, byte_sel};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext = {16'd0, half_sel};
            3'b010:  ext = rd_q;
            default: ext = '0;
         endcase
      end
   end

   // A reset landing on the ack cycle kills the pending ack.
   assign o_wb_ack   = vld_pipe[STAGES] & ~i_reset;
   assign o_wb_data  = o_wb_ack ? ext : '0;
   assign o_wb_stall = i_reset;

endmodule

// File: tb/tb_wb_block_ram.sv
// tb_wb_block_ram: scoreboard bench for wb_block_ram. Stimulus pushes the
// expected ack cycle and data; a negedge monitor pops and compares on acks.
module tb_wb_block_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        we;
   logic [2:0]  sel;
   logic [31:0] rdata;
   logic        stall;
   logic        ack;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   wb_block_ram dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_wb_stb  (stb),
      .i_addr    (addr),
      .i_data    (wd),
      .i_wb_we   (we),
      .i_wb_sel  (sel),
      .o_wb_data (rdata),
      .o_wb_stall(stall),
      .o_wb_ack  (ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: expired entries are missing acks; every ack must match the head.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_ack: no ack at cycle %0d, expected data %h", sb_q[0].due, sb_q[0].data);
         void'(sb_q.pop_front());
      end
      if (ack === 1'b1) begin
         if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: ack at cycle %0d data %h, none expected", cyc, rdata);
         end else begin
            chk("ack_data", rdata, sb_q[0].data);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic drive(input logic s, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input logic r);
      @(posedge clk);
      #1;
      stb = s; we = w; sel = f; addr = a; wd = d; rst = r;
   endtask

   // Accepted on the next edge, ack seen in the cycle after that edge.
   task automatic req(input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp);
      drive(1'b1, w, f, a, d, 1'b0);
      sb_q.push_back('{due: cyc + 1, data: exp});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stb = 1'b0; we = 1'b0; sel = 3'b010; addr = '0; wd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack",   {31'd0, ack},   32'd0);
      chk("rst_data",  rdata,          32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd1);
      drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("idle_stall", {31'd0, stall}, 32'd0);
      chk("idle_ack",   {31'd0, ack},   32'd0);
      chk("idle_data",  rdata,          32'd0);

      // word round trip
      req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0);
      req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF);
      idle(1);

      // byte merge and extension
      req(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0);
      req(1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h0);
      req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1122A544);
      req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFA5);
      req(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000A5);
      req(1'b0, 3'b000, 32'h10, 32'h0, 32'h00000044);
      req(1'b0, 3'b000, 32'h13, 32'h0, 32'h00000011);
      idle(1);

      // halfword, odd address forced down to even half
      req(1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0);
      req(1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000);
      req(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001);
      req(1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001);
      req(1'b0, 3'b101, 32'h23, 32'h0, 32'h00008001);
      req(1'b1, 3'b001, 32'h21, 32'hABCD7FFF, 32'h0);
      req(1'b0, 3'b010, 32'h20, 32'h0, 32'h80017FFF);
      req(1'b0, 3'b001, 32'h20, 32'h0, 32'h00007FFF);
      idle(2);

      // pipelined back-to-back
      req(1'b1, 3'b010, 32'h0, 32'h1, 32'h0);
      req(1'b0, 3'b010, 32'h0, 32'h0, 32'h1);
      req(1'b1, 3'b010, 32'h4, 32'h2, 32'h0);
      req(1'b0, 3'b010, 32'h4, 32'h0, 32'h2);
      idle(1);

      // address wrap
      req(1'b0, 3'b010, 32'h1010, 32'h0, 32'h1122A544);
      req(1'b1, 3'b010, 32'h1030, 32'hCAFEF00D, 32'h0);
      req(1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D);

      // invalid selects
      req(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0);
      req(1'b1, 3'b110, 32'h10, 32'hFFFFFFFF, 32'h0);
      req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1122A544);
      req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0);
      req(1'b0, 3'b111, 32'h10, 32'h0, 32'h0);
      idle(2);

      // reset on the ack cycle: load and store both lose their ack, the store
      // still commits, and a strobe during reset is dropped
      drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 3'b010, 32'h44, 32'h99, 1'b1);
      @(negedge clk);
      chk("mid_rst_stall", {31'd0, stall}, 32'd1);
      chk("mid_rst_ack",   {31'd0, ack},   32'd0);
      idle(1);
      drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h55, 1'b0);
      drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("st_rst_ack", {31'd0, ack}, 32'd0);
      idle(1);
      req(1'b0, 3'b010, 32'h40, 32'h0, 32'h55);
      req(1'b0, 3'b010, 32'h44, 32'h0, 32'h0);
      req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1122A544);
      idle(3);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_block_ram.md
Name: wb_block_ram

Overview:
- Single-port, byte-addressed synchronous block RAM with a pipelined Wishbone-style slave interface.
- Serves as the data memory of the RV32 core.
- Access size and signedness come from a 3-bit RISC-V funct3-style select, so the core drives load/store funct3 directly.
- All sub-word alignment, byte-lane merging and load sign/zero extension happen inside this block.

Parameters:
- XLEN, 32, data width in bits; only 32 is supported.
- AW, 12, number of byte-address bits decoded; depth is 2^(AW-2) words (1024 by default).
- INIT_FILE, "", hex file for preload; used only with BRAM_INIT_EN.

Ports:
- i_clk  in  1  single clock; all logic is on its rising edge.
- i_reset  in  1  reset, synchronous and active-high.
- i_wb_stb  in  1  request strobe; one access per cycle with stb high.
- i_addr  in  XLEN  byte address; bits above AW-1 are ignored, so addresses wrap.
- i_data  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
- i_wb_we  in  1  1 = store, 0 = load.
- i_wb_sel  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_wb_data  out  XLEN  load result, extended to 32 bits and valid while o_wb_ack is high.
- o_wb_stall  out  1  high means a request is not accepted this cycle.
- o_wb_ack  out  1  one-cycle completion pulse per accepted request.

Behaviour:
- Reset: on a rising edge with i_reset=1, o_wb_ack=0 and o_wb_data=0. Memory contents are not cleared.
- Stall: o_wb_stall=1 in the cycle reset is asserted, otherwise 0. Any stb arriving while i_reset=1 is dropped, with no write and no ack.
- Acceptance: a request is accepted on an edge where i_wb_stb=1, o_wb_stall=0 and i_reset=0. Back-to-back requests are accepted every cycle.
- Latency: o_wb_ack=1 exactly one cycle after acceptance, for both loads and stores, and 0 in all other cycles.
- Addressing: word index = i_addr[AW-1:2].
  - Byte lane = i_addr[1:0].
  - Halfword lane = i_addr[1]; i_addr[0] is ignored, so an odd-address half is forced down to the even half.
  - Word accesses ignore i_addr[1:0].
  - No misalignment fault is raised.
- Store:
  - 000: writes i_data[7:0] into the selected byte lane only.
  - 001: writes i_data[15:0] into the selected half only.
  - 010: writes the full word.
  - Other codes (011, 1xx): no memory change, but the store is still acked.
  - o_wb_data=0 during a store's ack.
- Load, on the ack cycle:
  - 000: selected byte, sign-extended.
  - 100: selected byte, zero-extended.
  - 001: selected half, sign-extended.
  - 101: selected half, zero-extended.
  - 010: full word.
  - 011, 110, 111: return 0.
- Ordering: a load issued the cycle after a store to the same word returns the newly written data.
- Reset mid-operation: if i_reset=1 in the cycle an ack would be produced, the ack is suppressed (o_wb_ack=0). A store accepted before reset has already committed.
- The memory array is inferred as block RAM: one registered read port, a byte-enable write port, and extension logic placed after the read register.

Optional Feature:
- Macro BRAM_INIT_EN.
- Defined: memory is preloaded at time zero via $readmemh(INIT_FILE).
- Undefined: all words are initialised to 0 at time zero; INIT_FILE is ignored.

Test Plan:
- Reset then idle: hold i_reset=1 for 2 cycles, release -> o_wb_ack=0, o_wb_data=0, and o_wb_stall=0 after release.
- Word round-trip: store 0xDEADBEEF, sel 010, at 0x10, then load 010 at 0x10 -> each op acks one cycle later; load returns 0xDEADBEEF.
- Byte merge and extension: store 0x000000A5, sel 000, at 0x11, over 0x11223344 -> word becomes 0x1122A544.
  - Load 000 at 0x11 returns 0xFFFFFFA5.
  - Load 100 at 0x11 returns 0x000000A5.
- Halfword: store 0x00008001, sel 001, at 0x22 -> word at 0x20 has upper half 0x8001.
  - Load 001 returns 0xFFFF8001.
  - Load 101 returns 0x00008001.
  - Load 101 at 0x23 returns 0x00008001 (low address bit ignored).
- Pipelined: 4 consecutive stb cycles (W store 0x1 at 0x0, W load 0x0, W store 0x2 at 0x4, W load 0x4) -> 4 consecutive acks; loads return 0x1 and 0x2.
- Wrap, invalid select and reset:
  - Load at 0x1000|0x10 returns word 0x10.
  - Store with sel 011 is acked and memory is unchanged.
  - Reset asserted on the cycle after a load is accepted -> no ack.
